// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
// The optional hardwired-zero word is selected with REGFILE_ZERO_REG_EN.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_word.sv
// One storage word: load-enabled register with asynchronous active-high reset.
module reg_word #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// 1W/2R register file with write-to-read bypass and a sequenced clear.
// Define REGFILE_ZERO_REG_EN to hardwire word 0 to zero.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] add_wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] add_rd0,
  input  logic [ADDR_W-1:0] add_rd1,
  input  logic              clr,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  clr_state_e        state;
  logic [ADDR_W-1:0] ptr;

  logic              wr_acc_c;
  logic [DEPTH-1:0]  load_c;
  logic [DATA_W-1:0] word_d_c;
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] rd0_nxt_c;
  logic [DATA_W-1:0] rd1_nxt_c;

  // A clear request wins over a same-edge write; nothing is written while clearing.
`ifdef REGFILE_ZERO_REG_EN
  assign wr_acc_c = wr_en && (state == IDLE) && !clr && (add_wr != '0);
`else
  assign wr_acc_c = wr_en && (state == IDLE) && !clr;
`endif

  always_comb begin
    load_c   = '0;
    word_d_c = wr_data;
    if (state == CLEAR) begin
      load_c[ptr] = 1'b1;
      word_d_c    = '0;
    end else if (wr_acc_c) begin
      load_c[add_wr] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk  (clk),
      .rst  (rst),
      .load (load_c[i]),
      .d    (word_d_c),
      .q    (word_q[i])
    );
  end

  // Clear writes never bypass, so reads see the pre-clear value of the word being cleared.
  always_comb begin
    rd0_nxt_c = (wr_acc_c && (add_rd0 == add_wr)) ? wr_data : word_q[add_rd0];
    rd1_nxt_c = (wr_acc_c && (add_rd1 == add_wr)) ? wr_data : word_q[add_rd1];
`ifdef REGFILE_ZERO_REG_EN
    if (add_rd0 == '0) rd0_nxt_c = '0;
    if (add_rd1 == '0) rd1_nxt_c = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      rd0   <= '0;
      rd1   <= '0;
    end else begin
      rd0 <= rd0_nxt_c;
      rd1 <= rd1_nxt_c;
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ADDR_W'(ptr + ADDR_W'(1));
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, reset-mid-clear
// sequence and randomized traffic against a behavioural model.
module tb_regfile_param;

  localparam int DEPTH = 4;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [7:0] W0  = 8'h00;
  localparam logic [7:0] W77 = 8'h00;
`else
  localparam logic [7:0] W0  = 8'h11;
  localparam logic [7:0] W77 = 8'h77;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] add_wr;
  logic [7:0] wr_data;
  logic [1:0] add_rd0;
  logic [1:0] add_rd1;
  logic       clr;
  logic [7:0] rd0;
  logic [7:0] rd1;
  logic       busy;

  regfile_param #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .add_wr  (add_wr),
    .wr_data (wr_data),
    .add_rd0 (add_rd0),
    .add_rd1 (add_rd1),
    .clr     (clr),
    .rd0     (rd0),
    .rd1     (rd1),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: memory array plus a countdown of remaining clear writes.
  logic [7:0] m_mem [DEPTH];
  int         m_clr_left;
  int         m_clr_idx;
  logic [7:0] m_rd0, m_rd1;
  logic       m_busy;

  function automatic logic [7:0] m_read(input logic [1:0] a, input bit acc,
                                        input logic [1:0] wa, input logic [7:0] wd);
    logic [7:0] v;
    v = (acc && a == wa) ? wd : m_mem[a];
`ifdef REGFILE_ZERO_REG_EN
    if (a == 2'd0) v = 8'h00;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_clr_left = 0;
    m_clr_idx  = 0;
    m_rd0 = 8'h00;
    m_rd1 = 8'h00;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    bit clearing;
    bit acc;
    clearing = (m_clr_left > 0);
    acc = wr_en && !clearing && !clr;
`ifdef REGFILE_ZERO_REG_EN
    if (add_wr == 2'd0) acc = 1'b0;
`endif
    m_rd0 = m_read(add_rd0, acc, add_wr, wr_data);
    m_rd1 = m_read(add_rd1, acc, add_wr, wr_data);
    if (clearing) begin
      m_mem[m_clr_idx] = 8'h00;
      m_clr_idx  = m_clr_idx + 1;
      m_clr_left = m_clr_left - 1;
    end else if (clr) begin
      m_clr_left = DEPTH;
      m_clr_idx  = 0;
    end else if (acc) begin
      m_mem[add_wr] = wr_data;
    end
    m_busy = (m_clr_left > 0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] a0, input logic [1:0] a1, input logic c);
    wr_en = we; add_wr = wa; wr_data = wd; add_rd0 = a0; add_rd1 = a1; clr = c;
  endtask

  // Apply current inputs across one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] a0;
    logic [1:0] a1;
    logic       c;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       eb;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd, logic [1:0] a0,
                              logic [1:0] a1, logic c, logic [7:0] e0, logic [7:0] e1,
                              logic eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.a0 = a0; v.a1 = a1; v.c = c;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 0, 8'h00, 2, 3, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(1, 2, 8'hA5, 1, 0, 0, 8'h00, 8'h00, 0);
    tbl[3]  = mk(0, 0, 8'h00, 2, 1, 0, 8'hA5, 8'h00, 0);
    tbl[4]  = mk(1, 3, 8'h3C, 3, 3, 0, 8'h3C, 8'h3C, 0);
    tbl[5]  = mk(0, 0, 8'h00, 3, 2, 0, 8'h3C, 8'hA5, 0);
    tbl[6]  = mk(1, 0, 8'h11, 0, 1, 0, W0,    8'h00, 0);
    tbl[7]  = mk(1, 1, 8'h22, 0, 1, 0, W0,    8'h22, 0);
    tbl[8]  = mk(1, 2, 8'h33, 2, 3, 0, 8'h33, 8'h3C, 0);
    tbl[9]  = mk(1, 3, 8'h44, 2, 3, 0, 8'h33, 8'h44, 0);
    tbl[10] = mk(1, 1, 8'hFF, 1, 3, 1, 8'h22, 8'h44, 1);
    tbl[11] = mk(1, 1, 8'hFF, 0, 1, 0, W0,    8'h22, 1);
    tbl[12] = mk(1, 1, 8'hFF, 1, 2, 0, 8'h22, 8'h33, 1);
    tbl[13] = mk(0, 0, 8'h00, 1, 2, 1, 8'h00, 8'h33, 1);
    tbl[14] = mk(0, 0, 8'h00, 2, 3, 0, 8'h00, 8'h44, 0);
    tbl[15] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0);
    tbl[16] = mk(0, 0, 8'h00, 2, 3, 0, 8'h00, 8'h00, 0);
    tbl[17] = mk(1, 1, 8'h5A, 1, 0, 0, 8'h5A, 8'h00, 0);
    tbl[18] = mk(0, 0, 8'h00, 1, 1, 0, 8'h5A, 8'h5A, 0);
    tbl[19] = mk(1, 0, 8'h77, 0, 1, 0, W77,   8'h5A, 0);
    tbl[20] = mk(0, 0, 8'h00, 0, 1, 0, W77,   8'h5A, 0);

    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    model_reset();
    #1;
    check("reset_rd0", rd0, 8'h00);
    check("reset_rd1", rd1, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1, tbl[i].c);
      step();
      check($sformatf("tbl%0d_rd0", i), rd0, tbl[i].e0);
      check($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e1);
      check($sformatf("tbl%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].eb});
    end

    // Reset in the middle of a clear sequence.
    drive(0, 0, 8'h00, 1, 1, 0);
    step();
    check("pre_rst_rd0", rd0, 8'h5A);
    drive(0, 0, 8'h00, 1, 1, 1);
    step();
    drive(0, 0, 8'h00, 1, 1, 0);
    step();
    step();
    check("midclr_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    #1;
    model_reset();
    check("midclr_rst_rd0", rd0, 8'h00);
    check("midclr_rst_rd1", rd1, 8'h00);
    check("midclr_rst_busy", {7'd0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 2, 8'h66, 2, 1, 0);
    step();
    check("post_rst_bypass", rd0, 8'h66);
    check("post_rst_rd1", rd1, 8'h00);
    check("post_rst_busy", {7'd0, busy}, 8'h00);
    drive(0, 0, 8'h00, 2, 2, 0);
    step();
    check("post_rst_read", rd1, 8'h66);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 19) == 0));
      step();
      check($sformatf("rnd%0d_rd0", n), rd0, m_rd0);
      check($sformatf("rnd%0d_rd1", n), rd1, m_rd1);
      check($sformatf("rnd%0d_busy", n), {7'd0, busy}, {7'd0, m_busy});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
